reg_bank_plus: RTL and testbench
================================

// Module: reg_bank_plus
// PURPOSE
//   Parametrised register bank: DEPTH registers of WIDTH bits, one write/modify port, two read ports.
//   Successor to the single fixed-width load/clear register in the datapath.
//   Each write cycle runs one in-place op (load, clear, inc, dec, shift, rotate) on the addressed register.
//   Zero/carry flags feed the control unit's branch logic; read ports feed the ALU operands.
// PARAMETERS
//   WIDTH   4   bits per register (>=2)
//   DEPTH   4   number of registers (>=2, need not be a power of 2)
//   ADDR_W  $clog2(DEPTH)   localparam, derived, not overridable
// PORTS
//   clk         in   1       rising-edge clock, sole clock domain
//   clear_n     in   1       synchronous active-low reset, sampled on rising clk
//   wr_en       in   1       execute op this cycle
//   op          in   3       operation code (see BEHAVIOUR)
//   wr_addr     in   ADDR_W  target register
//   data_in     in   WIDTH   operand for LOAD
//   rd_addr_a   in   ADDR_W  read port A address
//   rd_addr_b   in   ADDR_W  read port B address
//   data_out_a  out  WIDTH   registered read data A
//   data_out_b  out  WIDTH   registered read data B
//   flag_z      out  1       result of last executed op == 0
//   flag_c      out  1       carry/borrow/shifted-out bit of last executed op
//   op_err      out  1       one-cycle pulse: wr_addr >= DEPTH, op dropped
// BEHAVIOUR
//   Reset (clear_n==0 at edge): all registers, data_out_a/b, flag_z, flag_c, op_err = 0. Overrides wr_en.
//   Ops, on R=reg[wr_addr], result written back to reg[wr_addr]:
//     000 NOP   no write, flags hold
//     001 LOAD  R<=data_in;  C=0
//     010 CLR   R<=0;        C=0
//     011 INC   R<=R+1 mod 2^WIDTH; C=1 iff R was all-ones
//     100 DEC   R<=R-1 mod 2^WIDTH; C=1 iff R was 0 (borrow)
//     101 SHL   R<={R[W-2:0],0};    C=R[W-1]
//     110 SHR   R<={0,R[W-1:1]};    C=R[0]
//     111 ROL   R<={R[W-2:0],R[W-1]}; C=R[W-1]
//   Z = (result==0). Flags update only when wr_en=1, op!=NOP, address valid; otherwise hold.
//   Write latency: 1 cycle (result visible in reg array after the edge).
//   Read latency: 1 cycle; data_out_x at edge N+1 = reg[rd_addr_x] as updated at edge N+1
//     (write-first bypass: read of the address being written returns the new result).
//   Read address >= DEPTH: data_out_x <= 0, no error flagged.
//   wr_en=1 with wr_addr >= DEPTH: no register/flag change, op_err=1 for exactly that cycle; else op_err=0.
//   Read ports A and B may address the same register; both return identical data.
//   wr_en=0: op, wr_addr, data_in ignored.
// STRUCTURE
//   Package reg_bank_pkg: op encodings (OP_NOP..OP_ROL) as localparams, op width constant.
//   Sub-module reg_op_unit: combinational (op, R, data_in) -> (result, carry); instantiated once.
//   Top holds reg array, bypass mux, read registers, flag registers, address-range check.
// TESTING
//   Reset: set regs, drive clear_n=0 one edge with wr_en=1 -> all reads 0, flags 0, op_err 0.
//   W=4: LOAD r1=4'hF, INC r1 -> r1=0, Z=1, C=1; DEC r1 -> 4'hF, Z=0, C=1.
//   W=4: LOAD r2=4'b1001; SHL -> 0010 C=1; SHR -> 0001 C=0; ROL from 1000 -> 0001 C=1.
//   Bypass: same cycle INC r3 (=5) and rd_addr_a=r3 -> data_out_a=6 next cycle.
//   DEPTH=3: wr_en, wr_addr=3, LOAD 4'hA -> op_err one cycle, regs/flags unchanged; rd_addr=3 -> 0.
//   NOP and wr_en=0 after an op setting Z=1,C=1 -> flags hold; WIDTH=8, DEPTH=5 rerun of INC wrap.

Source files
------------

// File: rtl/reg_bank_plus_pkg.sv
// Shared op encodings for the register bank and its op unit.
package reg_bank_pkg;
  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 3'b000;
  localparam op_t OP_LOAD = 3'b001;
  localparam op_t OP_CLR  = 3'b010;
  localparam op_t OP_INC  = 3'b011;
  localparam op_t OP_DEC  = 3'b100;
  localparam op_t OP_SHL  = 3'b101;
  localparam op_t OP_SHR  = 3'b110;
  localparam op_t OP_ROL  = 3'b111;
endpackage

// File: rtl/reg_bank_plus_if.sv
// Write/modify port and two read ports of the register bank, plus status flags.
interface reg_bank_plus_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  import reg_bank_pkg::*;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  op_t               op;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  data_in;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  data_out_a;
  logic [WIDTH-1:0]  data_out_b;
  logic              flag_z;
  logic              flag_c;
  logic              op_err;

  modport master (
    output wr_en, op, wr_addr, data_in, rd_addr_a, rd_addr_b,
    input  data_out_a, data_out_b, flag_z, flag_c, op_err
  );
  modport slave (
    input  wr_en, op, wr_addr, data_in, rd_addr_a, rd_addr_b,
    output data_out_a, data_out_b, flag_z, flag_c, op_err
  );
endinterface

// File: rtl/reg_bank_plus_op_unit.sv
// Combinational in-place op: (op, R, data_in) -> (result, carry). NOP passes R through.
module reg_op_unit
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  always_comb begin
    result = r;
    carry  = 1'b0;
    case (op)
      OP_LOAD: result = data_in;
      OP_CLR:  result = '0;
      // Extra top bit captures carry-out on INC and borrow on DEC.
      OP_INC:  {carry, result} = {1'b0, r} + (WIDTH+1)'(1);
      OP_DEC:  {carry, result} = {1'b0, r} - (WIDTH+1)'(1);
      OP_SHL:  {carry, result} = {r, 1'b0};
      OP_SHR:  {result, carry} = {1'b0, r};
      OP_ROL: begin
        result = {r[WIDTH-2:0], r[WIDTH-1]};
        carry  = r[WIDTH-1];
      end
      default: begin
        result = r;
        carry  = 1'b0;
      end
    endcase
  end
endmodule

// File: rtl/reg_bank_plus.sv
// DEPTH x WIDTH register bank: one modify port, two registered read ports with write-first bypass.
// Out-of-range writes are dropped with a one-cycle op_err; out-of-range reads return 0.
module reg_bank_plus
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          clear_n,
  reg_bank_plus_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur, result, nxt_a, nxt_b;
  logic [WIDTH-1:0] out_a, out_b;
  logic             carry, z_q, c_q, err_q;
  logic             wr_ok, do_write, rd_a_ok, rd_b_ok;

  assign wr_ok    = int'(bus.wr_addr) < DEPTH;
  assign rd_a_ok  = int'(bus.rd_addr_a) < DEPTH;
  assign rd_b_ok  = int'(bus.rd_addr_b) < DEPTH;
  assign do_write = bus.wr_en && wr_ok && (bus.op != OP_NOP);

  always_comb begin
    cur = '0;
    if (wr_ok) cur = regs[bus.wr_addr];
  end

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .op      (bus.op),
    .r       (cur),
    .data_in (bus.data_in),
    .result  (result),
    .carry   (carry)
  );

  // Reads see the register contents as they will be after this edge.
  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    if (rd_a_ok) nxt_a = (do_write && bus.rd_addr_a == bus.wr_addr) ? result : regs[bus.rd_addr_a];
    if (rd_b_ok) nxt_b = (do_write && bus.rd_addr_b == bus.wr_addr) ? result : regs[bus.rd_addr_b];
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      out_a <= '0;
      out_b <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (do_write) begin
        regs[bus.wr_addr] <= result;
        z_q               <= (result == '0);
        c_q               <= carry;
      end
      out_a <= nxt_a;
      out_b <= nxt_b;
      err_q <= bus.wr_en && !wr_ok;
    end
  end

  assign bus.data_out_a = out_a;
  assign bus.data_out_b = out_b;
  assign bus.flag_z     = z_q;
  assign bus.flag_c     = c_q;
  assign bus.op_err     = err_q;
endmodule

// File: tb/tb_reg_bank_plus.sv
// Two bank instances (4-bit x 3, 8-bit x 5) driven from per-instance stimulus and
// compared against an arithmetic reference model of the register file.
module tb_reg_bank_plus;
  import reg_bank_pkg::*;

  logic clk = 1'b0;
  logic clear_n;
  always #5 clk = ~clk;

  reg_bank_plus_if #(.WIDTH(4), .DEPTH(3)) ifa ();
  reg_bank_plus_if #(.WIDTH(8), .DEPTH(5)) ifb ();

  reg_bank_plus #(.WIDTH(4), .DEPTH(3)) dut_a (.clk(clk), .clear_n(clear_n), .bus(ifa));
  reg_bank_plus #(.WIDTH(8), .DEPTH(5)) dut_b (.clk(clk), .clear_n(clear_n), .bus(ifb));

  int vectors = 0;
  int errs    = 0;

  // Stimulus, index 0 = 4x3 instance, 1 = 8x5 instance
  int st_en [2], st_op [2], st_wa [2], st_d [2], st_ra [2], st_rb [2];
  // Reference model
  int mreg [2][8];
  int moa [2], mob [2], mz [2], mc [2], merr [2];
  // Observed outputs
  int oa [2], ob [2], oz [2], oc [2], oe [2];

  task automatic set(input int i, input int en, input int op, input int wa,
                     input int d, input int ra, input int rb);
    st_en[i] = en; st_op[i] = op; st_wa[i] = wa;
    st_d[i]  = d;  st_ra[i] = ra; st_rb[i] = rb;
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int w, dep, modv, r, res, c;
      w    = (i == 1) ? 8 : 4;
      dep  = (i == 1) ? 5 : 3;
      modv = 1 << w;
      if (!clear_n) begin
        for (int k = 0; k < 8; k++) mreg[i][k] = 0;
        moa[i] = 0; mob[i] = 0; mz[i] = 0; mc[i] = 0; merr[i] = 0;
      end else begin
        merr[i] = (st_en[i] != 0 && st_wa[i] >= dep) ? 1 : 0;
        if (st_en[i] != 0 && st_wa[i] < dep && st_op[i] != 0) begin
          r = mreg[i][st_wa[i]];
          res = r; c = 0;
          case (st_op[i])
            1: res = st_d[i] % modv;
            2: res = 0;
            3: begin res = (r + 1) % modv;        c = (r == modv - 1) ? 1 : 0; end
            4: begin res = (r + modv - 1) % modv; c = (r == 0) ? 1 : 0; end
            5: begin res = (r * 2) % modv;        c = (r >= modv / 2) ? 1 : 0; end
            6: begin res = r / 2;                 c = r % 2; end
            default: begin
              c   = (r >= modv / 2) ? 1 : 0;
              res = (r * 2) % modv + c;
            end
          endcase
          mreg[i][st_wa[i]] = res;
          mz[i] = (res == 0) ? 1 : 0;
          mc[i] = c;
        end
        moa[i] = (st_ra[i] < dep) ? mreg[i][st_ra[i]] : 0;
        mob[i] = (st_rb[i] < dep) ? mreg[i][st_rb[i]] : 0;
      end
    end
  endtask

  // Drive at negedge, clock once, update the model, sample at the next negedge.
  task automatic tick();
    ifa.wr_en = st_en[0][0]; ifa.op = 3'(st_op[0]); ifa.wr_addr = 2'(st_wa[0]);
    ifa.data_in = 4'(st_d[0]); ifa.rd_addr_a = 2'(st_ra[0]); ifa.rd_addr_b = 2'(st_rb[0]);
    ifb.wr_en = st_en[1][0]; ifb.op = 3'(st_op[1]); ifb.wr_addr = 3'(st_wa[1]);
    ifb.data_in = 8'(st_d[1]); ifb.rd_addr_a = 3'(st_ra[1]); ifb.rd_addr_b = 3'(st_rb[1]);
    @(posedge clk);
    model_update();
    @(negedge clk);
    oa[0] = int'(ifa.data_out_a); ob[0] = int'(ifa.data_out_b);
    oz[0] = int'(ifa.flag_z); oc[0] = int'(ifa.flag_c); oe[0] = int'(ifa.op_err);
    oa[1] = int'(ifb.data_out_a); ob[1] = int'(ifb.data_out_b);
    oz[1] = int'(ifb.flag_z); oc[1] = int'(ifb.flag_c); oe[1] = int'(ifb.op_err);
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    set(0, 1, 1, 0, 3, 0, 1);
    set(1, 1, 1, 4, 8'hC3, 4, 4);
    tick();
    set(0, 1, 1, 1, 7, 0, 1);
    set(1, 1, 3, 4, 0, 4, 4);
    tick();
    // Reset must override a valid write on A and an out-of-range write on B.
    clear_n = 1'b0;
    set(0, 1, 1, 0, 15, 0, 1);
    set(1, 1, 1, 7, 8'hFF, 4, 4);
    tick();
    clear_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (oa[i] !== 0 || ob[i] !== 0 || oz[i] !== 0 || oc[i] !== 0 || oe[i] !== 0) begin
        errs++;
        $display("FAIL reset_out[%0d] got a=%0d b=%0d z=%0d c=%0d e=%0d want all 0",
                 i, oa[i], ob[i], oz[i], oc[i], oe[i]);
      end
    end
    idle();
    set(0, 0, 0, 0, 0, 0, 1);
    set(1, 0, 0, 0, 0, 4, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (oa[i] !== 0 || ob[i] !== 0) begin
        errs++;
        $display("FAIL reset_regs[%0d] got a=%0d b=%0d want 0 0", i, oa[i], ob[i]);
      end
    end
  endtask

  task automatic test_inc_dec_wrap();
    set(0, 1, 1, 1, 15, 1, 1);
    set(1, 1, 1, 4, 255, 4, 4);
    tick();
    set(0, 1, 3, 1, 0, 1, 1);
    set(1, 1, 3, 4, 0, 4, 4);
    tick();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (oa[i] !== 0 || oz[i] !== 1 || oc[i] !== 1) begin
        errs++;
        $display("FAIL inc_wrap[%0d] got r=%0d z=%0d c=%0d want 0 1 1", i, oa[i], oz[i], oc[i]);
      end
    end
    set(0, 1, 4, 1, 0, 1, 1);
    set(1, 1, 4, 4, 0, 4, 4);
    tick();
    vectors++;
    if (oa[0] !== 15 || oz[0] !== 0 || oc[0] !== 1) begin
      errs++;
      $display("FAIL dec_wrap[0] got r=%0d z=%0d c=%0d want 15 0 1", oa[0], oz[0], oc[0]);
    end
    vectors++;
    if (oa[1] !== 255 || oz[1] !== 0 || oc[1] !== 1) begin
      errs++;
      $display("FAIL dec_wrap[1] got r=%0d z=%0d c=%0d want 255 0 1", oa[1], oz[1], oc[1]);
    end
  endtask

  task automatic test_shift();
    int exp_r [4];
    int exp_c [4];
    int ops   [4];
    int ld    [4];
    exp_r = '{2, 1, 1, 0};  exp_c = '{1, 0, 1, 0};
    ops   = '{5, 6, 7, 0};  ld    = '{9, -1, 8, -1};
    idle();
    for (int k = 0; k < 3; k++) begin
      if (ld[k] >= 0) begin
        set(0, 1, 1, 2, ld[k], 2, 0);
        tick();
      end
      set(0, 1, ops[k], 2, 0, 2, 0);
      tick();
      vectors++;
      if (oa[0] !== exp_r[k] || oc[0] !== exp_c[k] || oz[0] !== 0) begin
        errs++;
        $display("FAIL shift_op%0d got r=%0d c=%0d z=%0d want %0d %0d 0",
                 ops[k], oa[0], oc[0], oz[0], exp_r[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    set(0, 1, 1, 2, 5, 0, 0);
    set(1, 1, 1, 3, 200, 0, 0);
    tick();
    set(0, 1, 3, 2, 0, 2, 2);
    set(1, 1, 3, 3, 0, 3, 3);
    tick();
    vectors++;
    if (oa[0] !== 6 || ob[0] !== 6) begin
      errs++;
      $display("FAIL bypass[0] got a=%0d b=%0d want 6 6", oa[0], ob[0]);
    end
    vectors++;
    if (oa[1] !== 201 || ob[1] !== 201) begin
      errs++;
      $display("FAIL bypass[1] got a=%0d b=%0d want 201 201", oa[1], ob[1]);
    end
  endtask

  task automatic test_range();
    idle();
    set(0, 1, 1, 1, 5, 1, 1);
    tick();
    set(0, 1, 1, 3, 10, 3, 1);
    set(1, 1, 2, 6, 0, 7, 5);
    tick();
    vectors++;
    if (oe[0] !== 1 || oz[0] !== 0 || oc[0] !== 0 || oa[0] !== 0 || ob[0] !== 5) begin
      errs++;
      $display("FAIL range_err[0] got e=%0d z=%0d c=%0d a=%0d b=%0d want 1 0 0 0 5",
               oe[0], oz[0], oc[0], oa[0], ob[0]);
    end
    vectors++;
    if (oe[1] !== 1 || oa[1] !== 0 || ob[1] !== 0) begin
      errs++;
      $display("FAIL range_err[1] got e=%0d a=%0d b=%0d want 1 0 0", oe[1], oa[1], ob[1]);
    end
    idle();
    set(0, 0, 1, 3, 10, 0, 2);
    tick();
    vectors++;
    if (oe[0] !== 0 || oe[1] !== 0 || oa[0] !== mreg[0][0] || ob[0] !== mreg[0][2]) begin
      errs++;
      $display("FAIL range_after got e=%0d/%0d a=%0d b=%0d want 0/0 %0d %0d",
               oe[0], oe[1], oa[0], ob[0], mreg[0][0], mreg[0][2]);
    end
  endtask

  task automatic test_flag_hold();
    idle();
    set(0, 1, 1, 0, 15, 0, 0);
    set(1, 1, 1, 0, 255, 0, 0);
    tick();
    set(0, 1, 3, 0, 0, 0, 0);
    set(1, 1, 3, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        set(0, 1, 0, 0, 9, 0, 0);
        set(1, 1, 0, 0, 9, 0, 0);
      end else begin
        set(0, 0, 1, 0, 9, 0, 0);
        set(1, 0, 5, 0, 9, 0, 0);
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (oz[i] !== 1 || oc[i] !== 1 || oa[i] !== 0) begin
          errs++;
          $display("FAIL flag_hold%0d[%0d] got z=%0d c=%0d r=%0d want 1 1 0",
                   k, i, oz[i], oc[i], oa[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      clear_n = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      set(0, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 3),
          $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      set(1, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 7));
      tick();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (oa[i] !== moa[i] || ob[i] !== mob[i] || oz[i] !== mz[i] ||
            oc[i] !== mc[i] || oe[i] !== merr[i]) begin
          errs++;
          $display("FAIL random[%0d] cyc %0d got a=%0d b=%0d z=%0d c=%0d e=%0d want %0d %0d %0d %0d %0d",
                   i, n, oa[i], ob[i], oz[i], oc[i], oe[i],
                   moa[i], mob[i], mz[i], mc[i], merr[i]);
        end
      end
    end
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n = 1'b0;
    idle();
    @(negedge clk);
    tick();
    clear_n = 1'b1;
    test_reset();
    test_inc_dec_wrap();
    test_shift();
    test_bypass();
    test_range();
    test_flag_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
